// File: rtl/lsu_pkg.sv
// Shared constants and decode helpers for the load/store unit.
// Access widths follow RISC-V funct3; states are plain localparams.
package lsu_pkg;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_D  = 3'b011;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;
    localparam logic [2:0] LS_WU = 3'b110;

    localparam logic [1:0] ERR_MISALIGN_LD = 2'b00;
    localparam logic [1:0] ERR_MISALIGN_ST = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT     = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL     = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Unsigned variants exist only for loads; 64-bit widths only on RV64.
    function automatic logic lsu_type_legal(input logic [2:0] t, input logic we,
                                            input logic is64);
        logic ok;
        ok = 1'b1;
        if (t == 3'b111)
            ok = 1'b0;
        if (we && t[2])
            ok = 1'b0;
        if (!is64 && (t == LS_D || t == LS_WU))
            ok = 1'b0;
        return ok;
    endfunction

    function automatic logic lsu_misaligned(input logic [2:0] addr_lo, input logic [1:0] sz);
        logic [2:0] m;
        case (sz)
            2'd0:    m = 3'b000;
            2'd1:    m = 3'b001;
            2'd2:    m = 3'b011;
            default: m = 3'b111;
        endcase
        return |(addr_lo & m);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store byte enables/replicated data and
// load shift plus sign/zero extension. Zero latency, no flow control.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter  int XLEN  = 32,
    localparam int NB    = XLEN / 8,
    localparam int OFF_W = $clog2(NB)
) (
    input  logic [2:0]       i_type,
    input  logic [OFF_W-1:0] i_off,
    input  logic [XLEN-1:0]  i_wdata,
    input  logic [XLEN-1:0]  i_rdata,
    output logic [NB-1:0]    o_be,
    output logic [XLEN-1:0]  o_wdata,
    output logic [XLEN-1:0]  o_rdata_ext
);

    int              w_nbytes;
    int              w_nbits;
    logic [NB-1:0]   w_mask;
    logic [XLEN-1:0] w_shift;
    logic            w_sign;

    assign w_nbytes = int'(1) << i_type[1:0];
    assign w_nbits  = 8 * w_nbytes;
    assign w_shift  = i_rdata >> {i_off, 3'b000};

    always_comb begin
        w_mask  = '0;
        o_wdata = '0;
        for (int i = 0; i < NB; i++) begin
            w_mask[i] = (i < w_nbytes);
            // each lane takes the source byte at the same position within the access size
            for (int s = 0; s < NB; s++) begin
                if (s == (i % w_nbytes))
                    o_wdata[8*i +: 8] = i_wdata[8*s +: 8];
            end
        end
        o_be = w_mask << i_off;
    end

    always_comb begin
        w_sign = 1'b0;
        for (int j = 0; j < XLEN; j++) begin
            if (j == w_nbits - 1)
                w_sign = w_shift[j] & ~i_type[2];
        end
        o_rdata_ext = w_shift;
        if (w_nbits < XLEN) begin
            for (int j = 0; j < XLEN; j++)
                o_rdata_ext[j] = (j < w_nbits) ? w_shift[j] : w_sign;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: core request -> req/ack bus -> one-cycle response.
// Bus starts the cycle after acceptance; req_ready is low from acceptance until back in IDLE.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [2:0]        i_req_type,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [XLEN-1:0]   i_req_wdata,
    output logic              o_bus_req,
    output logic              o_bus_we,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic [XLEN/8-1:0] o_bus_be,
    output logic [XLEN-1:0]   o_bus_wdata,
    input  logic              i_bus_ack,
    input  logic [XLEN-1:0]   i_bus_rdata,
    output logic              o_resp_valid,
    output logic [XLEN-1:0]   o_resp_rdata,
    output logic              o_resp_err,
    output logic [1:0]        o_err_cause,
    output logic              o_busy
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]        r_state;
    logic              r_we;
    logic [2:0]        r_type;
    logic [ADDR_W-1:0] r_addr;
    logic [XLEN-1:0]   r_wdata;
    logic [XLEN-1:0]   r_rdata;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_err;
    logic [1:0]        r_cause;

    logic              w_accept;
    logic              w_illegal;
    logic              w_misal;
    logic              w_timeout;
    logic              w_in_bus;
    logic              w_in_resp;
    logic [NB-1:0]     w_be;
    logic [XLEN-1:0]   w_wdata;
    logic [XLEN-1:0]   w_rdata_ext;

    assign w_in_bus  = (r_state == ST_BUS);
    assign w_in_resp = (r_state == ST_RESP);
    assign w_accept  = i_req_valid && (r_state == ST_IDLE);
    assign w_illegal = !lsu_type_legal(i_req_type, i_req_we, XLEN == 64);
    assign w_misal   = lsu_misaligned(i_req_addr[2:0], i_req_type[1:0]);
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

    lsu_lane_align #(.XLEN(XLEN)) u_align (
        .i_type      (r_type),
        .i_off       (r_addr[OFF_W-1:0]),
        .i_wdata     (r_wdata),
        .i_rdata     (r_rdata),
        .o_be        (w_be),
        .o_wdata     (w_wdata),
        .o_rdata_ext (w_rdata_ext)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_we    <= 1'b0;
            r_type  <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_cause <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_we    <= i_req_we;
                        r_type  <= i_req_type;
                        r_addr  <= i_req_addr;
                        r_wdata <= i_req_wdata;
                        r_cnt   <= '0;
                        // decode errors skip the bus entirely
                        if (w_illegal) begin
                            r_err   <= 1'b1;
                            r_cause <= ERR_ILLEGAL;
                            r_state <= ST_RESP;
                        end else if (w_misal) begin
                            r_err   <= 1'b1;
                            r_cause <= i_req_we ? ERR_MISALIGN_ST : ERR_MISALIGN_LD;
                            r_state <= ST_RESP;
                        end else begin
                            r_err   <= 1'b0;
                            r_cause <= '0;
                            r_state <= ST_BUS;
                        end
                    end
                end
                ST_BUS: begin
                    if (i_bus_ack) begin
                        r_rdata <= i_bus_rdata;
                        r_state <= ST_RESP;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_cause <= ERR_TIMEOUT;
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_req_ready  = (r_state == ST_IDLE);
    assign o_busy       = (r_state != ST_IDLE);
    assign o_bus_req    = w_in_bus;
    assign o_bus_we     = w_in_bus & r_we;
    assign o_bus_addr   = w_in_bus ? {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
    assign o_bus_be     = w_in_bus ? w_be : '0;
    assign o_bus_wdata  = w_in_bus ? w_wdata : '0;
    assign o_resp_valid = w_in_resp;
    assign o_resp_err   = w_in_resp & r_err;
    assign o_err_cause  = (w_in_resp & r_err) ? r_cause : 2'b00;
    assign o_resp_rdata = (w_in_resp & ~r_err & ~r_we) ? w_rdata_ext : '0;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Multi-cycle load/store unit between the core datapath (ALU address, rs2 data, rw_type) and the RAM/IO bus.
- Replaces the single-cycle direct RAM/IO connection with a req/ack handshake, so devices with wait states are supported.
- Provides byte-lane alignment, sign/zero extension, and misalignment and bus-timeout detection.
- Parametrised for XLEN 32 or 64. RV64 adds ld, lwu and sd.

Parameters:
- XLEN, 32, datapath width; legal values are 32 or 64.
- ADDR_W, 32, byte-address width.
- TIMEOUT, 15, maximum cycles in BUS without bus_ack before an error; 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  core requests an access.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_type  in  3  funct3: 000 b, 001 h, 010 w, 011 d (XLEN=64 only), 100 bu, 101 hu, 110 wu (XLEN=64 only).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data, right-aligned.
- bus_req  out  1  bus access active.
- bus_we  out  1  bus write.
- bus_addr  out  ADDR_W  address aligned down to XLEN/8 bytes.
- bus_be  out  XLEN/8  byte enables.
- bus_wdata  out  XLEN  lane-positioned store data.
- bus_ack  in  1  bus access complete; bus_rdata is valid in the same cycle.
- bus_rdata  in  XLEN  raw bus word.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- resp_err  out  1  access failed.
- err_cause  out  2  00 misaligned load, 01 misaligned store, 10 timeout, 11 illegal type.
- busy  out  1  state != IDLE.

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset values: every output is 0, except req_ready = 1. State = IDLE, timeout counter = 0.
- States: IDLE, BUS, RESP.
- IDLE: req_ready = 1. A request is accepted on a clk edge with req_valid & req_ready, and all request fields are registered.
  - Illegal type goes to RESP with cause 11. Illegal types are 111, stores with type >= 100, and 011/110 when XLEN = 32.
  - Misaligned address (addr mod size != 0) goes to RESP with cause 00 or 01.
  - Otherwise go to BUS.
- BUS: req_ready = 0. bus_req = 1, and bus_addr, bus_be, bus_wdata and bus_we are held stable until the ack.
  - bus_ack = 1: capture bus_rdata and go to RESP; bus_req falls on the next edge.
  - Timeout counter increments each BUS cycle without an ack. When counter == TIMEOUT-1 and there is no ack, go to RESP with cause 10.
  - If bus_ack arrives in the same cycle as the timeout, the ack wins.
- RESP: resp_valid = 1 for exactly one cycle. The next state is always IDLE, and no request is accepted during RESP.
- Latency:
  - Acceptance at edge t.
  - bus_req is high in cycle t+1.
  - An ack in cycle t+1+k gives resp_valid in cycle t+2+k.
  - An error detected at acceptance gives resp_valid in cycle t+1; no bus cycle is issued.
- Lanes:
  - off = addr[log2(XLEN/8)-1:0].
  - bus_be = size mask (1, 3, F, FF) << off.
  - bus_wdata = the low size bytes of req_wdata, replicated across all lanes.
- Loads: shift = bus_rdata >> (8*off), truncated to size.
  - Sign-extend for types 000, 001 and 010 when XLEN = 64.
  - Zero-extend for types 100, 101 and 110.
  - 010 with XLEN = 32, and 011, are full width.
- Boundary conditions:
  - bus_ack in IDLE or RESP is ignored.
  - rst during BUS: bus_req = 0 after that edge, the request is discarded, and no resp_valid is issued.
  - req_valid held through busy is not consumed until req_ready.

Decomposition:
- Shared package lsu_pkg:
  - funct3 width constants (LS_B, LS_H, LS_W, LS_D, LS_BU, LS_HU, LS_WU).
  - err_cause encodings.
  - State enum.
- One sub-module, lsu_lane_align (combinational): computes be/wdata from type and off, and the extended load data from type, off and rdata.
- The FSM, timeout counter and registers stay in load_store_unit.

Test Plan:
- XLEN=32, lb at addr 0x103, bus_rdata = 0x80112233, ack in the first BUS cycle -> bus_be = 0x8, bus_addr = 0x100, resp_rdata = 0xFFFFFF80, resp_valid 2 cycles after acceptance.
- sh at 0x202 with wdata 0x0000ABCD, ack after 3 wait cycles -> bus_be = 0xC, bus_wdata = 0xABCDABCD, fields stable for 4 BUS cycles, resp_err = 0.
- lw at 0x006 -> no bus_req, resp_valid next cycle, resp_err = 1, err_cause = 00; sb type 100 -> err_cause = 11.
- TIMEOUT=15, lhu at 0x10 with no ack -> bus_req high for exactly 15 cycles, then resp_err = 1, err_cause = 10; a second run with ack in the 15th cycle -> success.
- XLEN=64, lwu at 0x14, bus_rdata = 0x8000000100000000 -> resp_rdata = 0x0000000080000000; same access as lw -> 0xFFFFFFFF80000000.
- rst asserted during the 2nd BUS cycle -> bus_req = 0 next cycle, no resp_valid, req_ready = 1; a following lw completes normally.
